// File: rtl/apb_cmd_master.sv
// apb_cmd_master: APB4 master driven by a valid/ready command port.
// Requests are queued in a REQ_DEPTH-entry FIFO and executed strictly in
// order as SETUP/ACCESS transfers. Each completion is returned on a
// single-entry response channel.
//
// Optional feature macro: APB_CMD_MASTER_TIMEOUT_EN
//   When defined, ACCESS is aborted after TIMEOUT_CYCLES wait cycles. The
//   abort returns an error response and pulses timeout_o. When undefined,
//   ACCESS waits indefinitely for pready_i.
//
// Ports:
//   clk_i, arst_ni              clock, async active-low reset
//   req_valid_i/req_ready_o     command handshake
//   req_write_i/addr/wdata/strb command payload
//   rsp_valid_o/rsp_ready_i     response handshake
//   rsp_rdata_o/rsp_slverr_o    response payload
//   timeout_o                   one-cycle pulse on timeout abort
//   psel_o..pstrb_o             APB request signals (registered)
//   pready_i/prdata_i/pslverr_i APB completion signals
module apb_cmd_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REQ_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    arst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_slverr_o,
  output logic                    timeout_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PTR_WIDTH  = $clog2(REQ_DEPTH);
  localparam int unsigned CNT_WIDTH  = PTR_WIDTH + 1;

  // Reject configurations the FIFO pointer arithmetic cannot support.
  if (REQ_DEPTH < 2 || (REQ_DEPTH & (REQ_DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("apb_cmd_master: REQ_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES > 0");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state;

  logic [REQ_DEPTH-1:0]  fifo_write;
  logic [ADDR_WIDTH-1:0] fifo_addr  [REQ_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_wdata [REQ_DEPTH];
  logic [STRB_WIDTH-1:0] fifo_strb  [REQ_DEPTH];

  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] count_next;

  logic push;
  logic start;
  logic done;
  logic abort;
  logic pop;

  // Handshake and transfer-boundary decodes.
  assign push  = req_valid_i && req_ready_o;
  assign start = (state == IDLE) && (count != '0) && (!rsp_valid_o || rsp_ready_i);
  assign done  = (state == ACCESS) && pready_i;
  assign pop   = done || abort;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned WAIT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_WIDTH-1:0] wait_cnt;

  // Abort on the edge that would bring the wait count to TIMEOUT_CYCLES.
  assign abort = (state == ACCESS) && !pready_i &&
                 (wait_cnt == WAIT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Wait-cycle counter; cleared while in SETUP so it starts at 0 in ACCESS.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !pready_i) begin
      wait_cnt <= wait_cnt + WAIT_WIDTH'(1);
    end
  end
`else
  assign abort = 1'b0;
`endif

  // Occupancy after this edge's push/pop.
  always_comb begin
    count_next = count;
    count_next = count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
  end

  // Request storage; payload needs no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_write[wr_ptr] <= req_write_i;
      fifo_addr[wr_ptr]  <= req_addr_i;
      fifo_wdata[wr_ptr] <= req_wdata_i;
      fifo_strb[wr_ptr]  <= req_strb_i;
    end
  end

  // Control FSM, FIFO pointers, APB and response registers.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      req_ready_o  <= 1'b1;
      psel_o       <= 1'b0;
      penable_o    <= 1'b0;
      paddr_o      <= '0;
      pwrite_o     <= 1'b0;
      pwdata_o     <= '0;
      pstrb_o      <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_rdata_o  <= '0;
      rsp_slverr_o <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      count       <= count_next;
      req_ready_o <= (count_next != CNT_WIDTH'(REQ_DEPTH));
      timeout_o   <= abort;
      if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);

      case (state)
        IDLE: begin
          if (start) begin
            state     <= SETUP;
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
            paddr_o   <= fifo_addr[rd_ptr];
            pwrite_o  <= fifo_write[rd_ptr];
            // Reads drive no data and no strobes.
            pwdata_o  <= fifo_write[rd_ptr] ? fifo_wdata[rd_ptr] : '0;
            pstrb_o   <= fifo_write[rd_ptr] ? fifo_strb[rd_ptr]  : '0;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          penable_o <= 1'b1;
        end
        ACCESS: begin
          if (pop) begin
            state     <= IDLE;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
        end
      endcase

      // A new completion cannot overlap a pending response: SETUP is only
      // entered once the slot is free.
      if (pop) begin
        rsp_valid_o  <= 1'b1;
        rsp_rdata_o  <= (done && !pwrite_o) ? prdata_i : '0;
        rsp_slverr_o <= done ? pslverr_i : 1'b1;
      end else if (rsp_ready_i) begin
        rsp_valid_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model (request queue, transfer age, response slot).
module tb_apb_cmd_master;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;
  localparam logic [31:0] KEY   = 32'h5A5A_0000;

  logic          clk_i = 1'b0;
  logic          arst_ni;
  logic          req_valid_i, req_ready_o, req_write_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic [SW-1:0] req_strb_i;
  logic          rsp_valid_o, rsp_ready_i, rsp_slverr_o, timeout_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          psel_o, penable_o, pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic [SW-1:0] pstrb_o;
  logic          pready_i, pslverr_i;
  logic [DW-1:0] prdata_i;

  apb_cmd_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REQ_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_slverr_o(rsp_slverr_o), .timeout_o(timeout_o),
    .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
  } req_t;

  req_t          mq[$];
  req_t          mr;
  int            m_age  = 0;   // cycles since the transfer began (0 = no transfer)
  int            m_wait = 0;   // ACCESS cycles spent with pready low
  logic          m_rsp_v = 0, m_err = 0, m_tmo = 0, m_write = 0;
  logic [DW-1:0] m_rdata = '0, m_wdata = '0;
  logic [AW-1:0] m_addr = '0;
  logic [SW-1:0] m_strb = '0;
  logic          m_push, m_free;

  always @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      mq.delete();
      m_age = 0; m_wait = 0; m_rsp_v = 0; m_err = 0; m_tmo = 0;
      m_rdata = '0; m_addr = '0; m_write = 0; m_wdata = '0; m_strb = '0;
    end else begin
      m_push = req_valid_i && (mq.size() != DEPTH);
      m_free = !m_rsp_v || rsp_ready_i;
      if (m_rsp_v && rsp_ready_i) m_rsp_v = 0;
      m_tmo = 0;
      if (m_age == 0) begin
        if (mq.size() > 0 && m_free) begin
          mr = mq[0];
          m_age = 1;
          m_addr = mr.addr; m_write = mr.write;
          m_wdata = mr.write ? mr.wdata : '0;
          m_strb  = mr.write ? mr.strb  : '0;
        end
      end else if (m_age == 1) begin
        m_age = 2; m_wait = 0;
      end else if (pready_i) begin
        m_rsp_v = 1; m_rdata = m_write ? '0 : prdata_i; m_err = pslverr_i;
        void'(mq.pop_front()); m_age = 0;
      end else begin
        m_wait++;
        m_age++;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        if (m_wait == TMO) begin
          m_rsp_v = 1; m_rdata = '0; m_err = 1; m_tmo = 1;
          void'(mq.pop_front()); m_age = 0;
        end
`endif
      end
      if (m_push) mq.push_back('{req_write_i, req_addr_i, req_wdata_i, req_strb_i});
      #1;
      if (arst_ni) begin
        chk("m_req_ready", req_ready_o, mq.size() != DEPTH);
        chk("m_psel", psel_o, m_age > 0);
        chk("m_penable", penable_o, m_age >= 2);
        chk("m_paddr", paddr_o, m_addr);
        chk("m_pwrite", pwrite_o, m_write);
        chk("m_pwdata", pwdata_o, m_wdata);
        chk("m_pstrb", pstrb_o, m_strb);
        chk("m_rsp_valid", rsp_valid_o, m_rsp_v);
        if (m_rsp_v) begin
          chk("m_rsp_rdata", rsp_rdata_o, m_rdata);
          chk("m_rsp_slverr", rsp_slverr_o, m_err);
        end
        chk("m_timeout", timeout_o, m_tmo);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic echo = 0, err_zero = 0;

  // Advance to the next falling edge; optionally act as an echoing slave.
  task automatic step();
    @(negedge clk_i);
    if (echo) begin
      prdata_i  = paddr_o ^ KEY;
      pslverr_i = err_zero && (paddr_o == '0);
    end
  endtask

  task automatic offer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s);
    req_valid_i = 1; req_write_i = w; req_addr_i = a; req_wdata_i = d; req_strb_i = s;
  endtask

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] a0;
  int acc, got, n;

  initial begin
    arst_ni = 0; req_valid_i = 0; req_write_i = 0; req_addr_i = '0; req_wdata_i = '0;
    req_strb_i = '0; rsp_ready_i = 1; pready_i = 1; prdata_i = '0; pslverr_i = 0;
    repeat (2) step();
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_psel", psel_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_paddr", paddr_o, 0);
    chk("rst_timeout", timeout_o, 0);
    arst_ni = 1;
    repeat (2) step();

    // T1: single write, zero wait states.
    offer(1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF);
    step(); req_valid_i = 0;
    step();
    chk("t1_psel", psel_o, 1);
    chk("t1_penable_setup", penable_o, 0);
    chk("t1_paddr", paddr_o, 32'h1000_0004);
    chk("t1_pwdata", pwdata_o, 32'hDEAD_BEEF);
    chk("t1_pstrb", pstrb_o, 4'hF);
    chk("t1_pwrite", pwrite_o, 1);
    step();
    chk("t1_penable", penable_o, 1);
    step();
    chk("t1_rsp_valid", rsp_valid_o, 1);
    chk("t1_rsp_rdata", rsp_rdata_o, 0);
    chk("t1_rsp_slverr", rsp_slverr_o, 0);
    chk("t1_penable_done", penable_o, 0);
    repeat (2) step();

    // T2: read with 3 wait states.
    pready_i = 0; prdata_i = 32'hCAFE_F00D;
    offer(0, 32'h1000_0008, 32'h1234_5678, 4'hF);
    step(); req_valid_i = 0;
    step();
    chk("t2_pstrb", pstrb_o, 0);
    chk("t2_pwdata", pwdata_o, 0);
    chk("t2_pwrite", pwrite_o, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_penable", penable_o, 1);
      chk("t2_paddr", paddr_o, 32'h1000_0008);
    end
    pready_i = 1;
    step();
    chk("t2_rsp_valid", rsp_valid_o, 1);
    chk("t2_rsp_rdata", rsp_rdata_o, 32'hCAFE_F00D);
    chk("t2_penable_done", penable_o, 0);
    repeat (2) step();

    // T3: response backpressure with six back-to-back offers.
    echo = 1; rsp_ready_i = 0; acc = 0; exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      a0 = 32'h2000_0000 + 32'(i * 4);
      offer(0, a0, '0, '0);
      if (req_ready_o) begin exp_q.push_back(a0); acc++; end
      step();
    end
    req_valid_i = 0;
    chk("t3_accepted", acc, 5);
    chk("t3_req_ready", req_ready_o, 0);
    chk("t3_rsp_pending", rsp_valid_o, 1);
    rsp_ready_i = 1; got = 0;
    for (int c = 0; c < 100 && got < acc; c++) begin
      if (rsp_valid_o) begin
        chk("t3_order", rsp_rdata_o, exp_q[got] ^ KEY);
        got++;
      end
      step();
    end
    chk("t3_rsp_count", got, 5);
    repeat (2) step();

    // T4: slave error on addr 0, next request normal.
    err_zero = 1; exp_q.delete();
    offer(0, 32'h0, '0, '0); step();
    offer(0, 32'h4, '0, '0); step();
    req_valid_i = 0; got = 0;
    for (int c = 0; c < 40 && got < 2; c++) begin
      if (rsp_valid_o) begin
        chk("t4_slverr", rsp_slverr_o, (got == 0) ? 1 : 0);
        chk("t4_rdata", rsp_rdata_o, ((got == 0) ? 32'h0 : 32'h4) ^ KEY);
        got++;
      end
      step();
    end
    chk("t4_rsp_count", got, 2);
    err_zero = 0; echo = 0;
    repeat (2) step();

    // T5: reset during ACCESS with two requests queued.
    pready_i = 0;
    offer(0, 32'h3000, '0, '0); step();
    offer(0, 32'h3004, '0, '0); step();
    req_valid_i = 0;
    for (int c = 0; c < 10 && !penable_o; c++) step();
    chk("t5_in_access", penable_o, 1);
    #2 arst_ni = 0;
    #1;
    chk("t5_rst_psel", psel_o, 0);
    chk("t5_rst_penable", penable_o, 0);
    chk("t5_rst_rsp_valid", rsp_valid_o, 0);
    chk("t5_rst_req_ready", req_ready_o, 1);
    step();
    arst_ni = 1; pready_i = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t5_no_stale_rsp", rsp_valid_o, 0);
      chk("t5_no_stale_psel", psel_o, 0);
    end

    // T6: pready stuck low.
    pready_i = 0;
    offer(0, 32'h4000, '0, '0);
    step(); req_valid_i = 0;
    step();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (penable_o) n++;
      else break;
    end
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    chk("t6_access_cycles", n, TMO);
    chk("t6_psel_abort", psel_o, 0);
    chk("t6_timeout", timeout_o, 1);
    chk("t6_rsp_valid", rsp_valid_o, 1);
    chk("t6_rsp_slverr", rsp_slverr_o, 1);
    chk("t6_rsp_rdata", rsp_rdata_o, 0);
    step();
    chk("t6_timeout_pulse", timeout_o, 0);
    pready_i = 1;
`else
    chk("t6_access_cycles", n, 40);
    chk("t6_timeout", timeout_o, 0);
    chk("t6_no_rsp", rsp_valid_o, 0);
    pready_i = 1;
    step();
    chk("t6_late_rsp", rsp_valid_o, 1);
`endif
    repeat (3) step();

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 2000; i++) begin
      req_valid_i = ($urandom_range(1, 0) == 1);
      req_write_i = ($urandom_range(1, 0) == 1);
      req_addr_i  = $urandom;
      req_wdata_i = $urandom;
      req_strb_i  = SW'($urandom);
      rsp_ready_i = ($urandom_range(9, 0) < 7);
      pready_i    = ($urandom_range(9, 0) < 7);
      prdata_i    = $urandom;
      pslverr_i   = ($urandom_range(7, 0) == 0);
      step();
    end
    req_valid_i = 0; rsp_ready_i = 1; pready_i = 1;
    repeat (40) step();
    chk("end_rsp_drained", rsp_valid_o, 0);
    chk("end_idle", psel_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
